// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the 64-bit ALU: captures decoded fields, decodes the
// ALU control code, resolves EX/MEM and MEM/WB forwarding and raises load-use bubbles.
module id_ex_operand_stage #(
  parameter int DATA_W = 64,
  parameter int RA_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs1_data_i,
  input  logic [DATA_W-1:0] id_rs2_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [RA_W-1:0]   id_rs1_i,
  input  logic [RA_W-1:0]   id_rs2_i,
  input  logic [RA_W-1:0]   id_rd_i,
  input  logic [1:0]        id_alu_op_i,
  input  logic [3:0]        id_funct_i,
  input  logic              id_alu_src_i,
  input  logic [4:0]        id_ctl_i,
  input  logic              exmem_reg_write_i,
  input  logic [RA_W-1:0]   exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [RA_W-1:0]   memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [3:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] ex_store_data_o,
  output logic              ex_valid_o,
  output logic [RA_W-1:0]   ex_rd_o,
  output logic [4:0]        ex_ctl_o,
  output logic              load_use_hazard_o
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Bit 3 of the control bundle is mem_read: {reg_write, mem_read, mem_write, mem_to_reg, branch}
  localparam int CTL_MEM_READ = 3;

  function automatic logic [3:0] alu_ctrl_decode(input logic [1:0] op, input logic [3:0] funct);
    logic [3:0] code_s;
    code_s = ALU_ADD;
    case (op)
      2'b00: code_s = ALU_ADD;
      2'b01: code_s = ALU_SUB;
      2'b10: begin
        case (funct)
          4'b0000:          code_s = ALU_ADD;
          4'b1000:          code_s = ALU_SUB;
          4'b0111:          code_s = ALU_AND;
          4'b0110:          code_s = ALU_OR;
          4'b0010:          code_s = ALU_SLT;
          4'b0100, 4'b1100: code_s = ALU_NOR;
          default:          code_s = ALU_ADD;
        endcase
      end
      2'b11: begin
        case (funct[2:0])
          3'b000:  code_s = ALU_ADD;
          3'b111:  code_s = ALU_AND;
          3'b110:  code_s = ALU_OR;
          3'b010:  code_s = ALU_SLT;
          default: code_s = ALU_ADD;
        endcase
      end
      default: code_s = ALU_ADD;
    endcase
    return code_s;
  endfunction

  // EX/MEM has priority over MEM/WB; x0 and empty slots are never forwarded.
  function automatic logic [DATA_W-1:0] fwd_select(
    input logic              slot_valid,
    input logic [RA_W-1:0]   rs,
    input logic [DATA_W-1:0] reg_data,
    input logic              exmem_we,
    input logic [RA_W-1:0]   exmem_rd,
    input logic [DATA_W-1:0] exmem_data,
    input logic              memwb_we,
    input logic [RA_W-1:0]   memwb_rd,
    input logic [DATA_W-1:0] memwb_data
  );
    logic [DATA_W-1:0] sel_s;
    if (slot_valid && exmem_we && (exmem_rd != {RA_W{1'b0}}) && (exmem_rd == rs)) begin
      sel_s = exmem_data;
    end else if (slot_valid && memwb_we && (memwb_rd != {RA_W{1'b0}}) && (memwb_rd == rs)) begin
      sel_s = memwb_data;
    end else begin
      sel_s = reg_data;
    end
    return sel_s;
  endfunction

  logic              ex_valid_r;
  logic [4:0]        ex_ctl_r;
  logic [RA_W-1:0]   ex_rd_r;
  logic [RA_W-1:0]   ex_rs1_r;
  logic [RA_W-1:0]   ex_rs2_r;
  logic [DATA_W-1:0] rs1_data_r;
  logic [DATA_W-1:0] rs2_data_r;
  logic [DATA_W-1:0] imm_r;
  logic              alu_src_r;
  logic [3:0]        alu_ctrl_r;

  logic              hazard_s;
  logic [DATA_W-1:0] fwd_rs1_s;
  logic [DATA_W-1:0] fwd_rs2_s;

  // Load-use detection against the instruction currently sitting in ID.
  always_comb begin
    hazard_s = 1'b0;
    if (!rst_i && ex_valid_r && ex_ctl_r[CTL_MEM_READ] && id_valid_i &&
        (ex_rd_r != {RA_W{1'b0}}) && ((ex_rd_r == id_rs1_i) || (ex_rd_r == id_rs2_i))) begin
      hazard_s = 1'b1;
    end else begin
      hazard_s = 1'b0;
    end
  end

  // Stage register: reset/flush clear, stall holds, hazard inserts a bubble, else capture.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i || (!stall_i && hazard_s)) begin
      ex_valid_r <= 1'b0;
      ex_ctl_r   <= 5'b00000;
      ex_rd_r    <= {RA_W{1'b0}};
      ex_rs1_r   <= {RA_W{1'b0}};
      ex_rs2_r   <= {RA_W{1'b0}};
      rs1_data_r <= {DATA_W{1'b0}};
      rs2_data_r <= {DATA_W{1'b0}};
      imm_r      <= {DATA_W{1'b0}};
      alu_src_r  <= 1'b0;
      alu_ctrl_r <= ALU_ADD;
    end else if (!stall_i) begin
      ex_valid_r <= id_valid_i;
      ex_ctl_r   <= id_valid_i ? id_ctl_i : 5'b00000;
      ex_rd_r    <= id_rd_i;
      ex_rs1_r   <= id_rs1_i;
      ex_rs2_r   <= id_rs2_i;
      rs1_data_r <= id_rs1_data_i;
      rs2_data_r <= id_rs2_data_i;
      imm_r      <= id_imm_i;
      alu_src_r  <= id_alu_src_i;
      alu_ctrl_r <= alu_ctrl_decode(id_alu_op_i, id_funct_i);
    end
  end

  // Operand forwarding on the registered source addresses.
  always_comb begin
    fwd_rs1_s = fwd_select(ex_valid_r, ex_rs1_r, rs1_data_r,
                           exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                           memwb_reg_write_i, memwb_rd_i, memwb_result_i);
    fwd_rs2_s = fwd_select(ex_valid_r, ex_rs2_r, rs2_data_r,
                           exmem_reg_write_i, exmem_rd_i, exmem_result_i,
                           memwb_reg_write_i, memwb_rd_i, memwb_result_i);
  end

  assign alu_src1_o        = fwd_rs1_s;
  assign alu_src2_o        = alu_src_r ? imm_r : fwd_rs2_s;
  assign ex_store_data_o   = fwd_rs2_s;
  assign alu_ctrl_o        = alu_ctrl_r;
  assign ex_valid_o        = ex_valid_r;
  assign ex_rd_o           = ex_rd_r;
  assign ex_ctl_o          = ex_ctl_r;
  assign load_use_hazard_o = hazard_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage: decode, forwarding, load-use
// bubbles, stall/flush and reset priority, with hand-computed expectations.
module tb_id_ex_operand_stage;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, id_valid_i;
  logic [63:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic [1:0]  id_alu_op_i;
  logic [3:0]  id_funct_i;
  logic        id_alu_src_i;
  logic [4:0]  id_ctl_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [63:0] exmem_result_i, memwb_result_i;
  logic [63:0] alu_src1_o, alu_src2_o, ex_store_data_o;
  logic [3:0]  alu_ctrl_o;
  logic        ex_valid_o, load_use_hazard_o;
  logic [4:0]  ex_rd_o, ex_ctl_o;

  int tests_run = 0;
  int tests_failed = 0;

  id_ex_operand_stage #(.DATA_W(64), .RA_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_alu_op_i(id_alu_op_i), .id_funct_i(id_funct_i), .id_alu_src_i(id_alu_src_i),
    .id_ctl_i(id_ctl_i), .exmem_reg_write_i(exmem_reg_write_i), .exmem_rd_i(exmem_rd_i),
    .exmem_result_i(exmem_result_i), .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_rd_i(memwb_rd_i), .memwb_result_i(memwb_result_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .ex_store_data_o(ex_store_data_o), .ex_valid_o(ex_valid_o), .ex_rd_o(ex_rd_o),
    .ex_ctl_o(ex_ctl_o), .load_use_hazard_o(load_use_hazard_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_inputs();
    stall_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0;
    id_rs1_data_i = 64'd0; id_rs2_data_i = 64'd0; id_imm_i = 64'd0;
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rd_i = 5'd0;
    id_alu_op_i = 2'b00; id_funct_i = 4'b0000; id_alu_src_i = 1'b0; id_ctl_i = 5'b00000;
    exmem_reg_write_i = 1'b0; exmem_rd_i = 5'd0; exmem_result_i = 64'd0;
    memwb_reg_write_i = 1'b0; memwb_rd_i = 5'd0; memwb_result_i = 64'd0;
  endtask

  task automatic drive_id(input logic [1:0] op, input logic [3:0] funct, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [63:0] d1,
                          input logic [63:0] d2, input logic [63:0] imm, input logic src,
                          input logic [4:0] ctl);
    id_valid_i = 1'b1; id_alu_op_i = op; id_funct_i = funct;
    id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm;
    id_alu_src_i = src; id_ctl_i = ctl;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    tests_run += 8;
    if (ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b want 0", ex_valid_o); end
    if (ex_ctl_o !== 5'b00000) begin tests_failed++; $display("FAIL reset_ctl got %b want 00000", ex_ctl_o); end
    if (ex_rd_o !== 5'd0) begin tests_failed++; $display("FAIL reset_rd got %0d want 0", ex_rd_o); end
    if (alu_src1_o !== 64'd0) begin tests_failed++; $display("FAIL reset_src1 got %h want 0", alu_src1_o); end
    if (alu_src2_o !== 64'd0) begin tests_failed++; $display("FAIL reset_src2 got %h want 0", alu_src2_o); end
    if (ex_store_data_o !== 64'd0) begin tests_failed++; $display("FAIL reset_store got %h want 0", ex_store_data_o); end
    if (alu_ctrl_o !== 4'b0010) begin tests_failed++; $display("FAIL reset_ctrl got %b want 0010", alu_ctrl_o); end
    if (load_use_hazard_o !== 1'b0) begin tests_failed++; $display("FAIL reset_hazard got %0b want 0", load_use_hazard_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_decode();
    logic [1:0] ops [10];
    logic [3:0] fns [10];
    logic [3:0] exp [10];
    ops = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10};
    fns = '{4'b0111, 4'b0000, 4'b0111, 4'b0110, 4'b0010, 4'b0100, 4'b1100, 4'b1111, 4'b1001, 4'b0001};
    exp = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b1100, 4'b0000, 4'b0010, 4'b0010};
    clear_inputs();
    drive_id(2'b10, 4'b1000, 5'd1, 5'd2, 5'd3, 64'd9, 64'd4, 64'd0, 1'b0, 5'b10000);
    @(negedge clk_i);
    tests_run += 6;
    if (alu_ctrl_o !== 4'b0110) begin tests_failed++; $display("FAIL dec_sub_ctrl got %b want 0110", alu_ctrl_o); end
    if (alu_src1_o !== 64'd9) begin tests_failed++; $display("FAIL dec_sub_src1 got %0d want 9", alu_src1_o); end
    if (alu_src2_o !== 64'd4) begin tests_failed++; $display("FAIL dec_sub_src2 got %0d want 4", alu_src2_o); end
    if (ex_valid_o !== 1'b1) begin tests_failed++; $display("FAIL dec_valid got %0b want 1", ex_valid_o); end
    if (ex_rd_o !== 5'd3) begin tests_failed++; $display("FAIL dec_rd got %0d want 3", ex_rd_o); end
    if (ex_ctl_o !== 5'b10000) begin tests_failed++; $display("FAIL dec_ctl got %b want 10000", ex_ctl_o); end
    for (int i = 0; i < 10; i++) begin
      id_alu_op_i = ops[i]; id_funct_i = fns[i];
      @(negedge clk_i);
      tests_run++;
      if (alu_ctrl_o !== exp[i]) begin
        tests_failed++;
        $display("FAIL dec_table[%0d] op=%b funct=%b got %b want %b", i, ops[i], fns[i], alu_ctrl_o, exp[i]);
      end
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    drive_id(2'b00, 4'b0000, 5'd5, 5'd6, 5'd8, 64'hAA, 64'hBB, 64'h33, 1'b1, 5'b10000);
    exmem_reg_write_i = 1'b1; exmem_rd_i = 5'd5; exmem_result_i = 64'h11;
    memwb_reg_write_i = 1'b1; memwb_rd_i = 5'd5; memwb_result_i = 64'h22;
    @(negedge clk_i);
    tests_run += 3;
    if (alu_src1_o !== 64'h11) begin tests_failed++; $display("FAIL fwd_exmem got %h want 11", alu_src1_o); end
    if (alu_src2_o !== 64'h33) begin tests_failed++; $display("FAIL fwd_imm_src2 got %h want 33", alu_src2_o); end
    if (ex_store_data_o !== 64'hBB) begin tests_failed++; $display("FAIL fwd_store_nomatch got %h want bb", ex_store_data_o); end
    exmem_rd_i = 5'd0;
    #1;
    tests_run++;
    if (alu_src1_o !== 64'h22) begin tests_failed++; $display("FAIL fwd_memwb got %h want 22", alu_src1_o); end
    memwb_rd_i = 5'd6;
    #1;
    tests_run += 3;
    if (alu_src1_o !== 64'hAA) begin tests_failed++; $display("FAIL fwd_none got %h want aa", alu_src1_o); end
    if (ex_store_data_o !== 64'h22) begin tests_failed++; $display("FAIL fwd_store_memwb got %h want 22", ex_store_data_o); end
    if (alu_src2_o !== 64'h33) begin tests_failed++; $display("FAIL fwd_src2_still_imm got %h want 33", alu_src2_o); end
    // x0 must not be forwarded even when a writer targets x0
    drive_id(2'b00, 4'b0000, 5'd0, 5'd0, 5'd8, 64'd0, 64'd0, 64'd0, 1'b0, 5'b10000);
    exmem_rd_i = 5'd0; exmem_result_i = 64'h99; memwb_rd_i = 5'd0;
    @(negedge clk_i);
    tests_run++;
    if (alu_src1_o !== 64'd0) begin tests_failed++; $display("FAIL fwd_x0 got %h want 0", alu_src1_o); end
    // an empty slot keeps its registered data
    drive_id(2'b00, 4'b0000, 5'd5, 5'd6, 5'd8, 64'h44, 64'h55, 64'd0, 1'b0, 5'b10000);
    id_valid_i = 1'b0; exmem_rd_i = 5'd5;
    @(negedge clk_i);
    tests_run += 2;
    if (alu_src1_o !== 64'h44) begin tests_failed++; $display("FAIL fwd_invalid_slot got %h want 44", alu_src1_o); end
    if (ex_ctl_o !== 5'b00000) begin tests_failed++; $display("FAIL invalid_ctl got %b want 00000", ex_ctl_o); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    drive_id(2'b00, 4'b0000, 5'd1, 5'd2, 5'd7, 64'd1, 64'd2, 64'd8, 1'b1, 5'b11010);
    @(negedge clk_i);
    drive_id(2'b10, 4'b0000, 5'd3, 5'd7, 5'd9, 64'd3, 64'd4, 64'd0, 1'b0, 5'b10000);
    id_valid_i = 1'b0;
    #1;
    tests_run++;
    if (load_use_hazard_o !== 1'b0) begin tests_failed++; $display("FAIL lu_id_invalid got %0b want 0", load_use_hazard_o); end
    id_valid_i = 1'b1;
    #1;
    tests_run++;
    if (load_use_hazard_o !== 1'b1) begin tests_failed++; $display("FAIL lu_hazard got %0b want 1", load_use_hazard_o); end
    @(negedge clk_i);
    tests_run += 3;
    if (ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL lu_bubble_valid got %0b want 0", ex_valid_o); end
    if (ex_ctl_o !== 5'b00000) begin tests_failed++; $display("FAIL lu_bubble_ctl got %b want 00000", ex_ctl_o); end
    if (load_use_hazard_o !== 1'b0) begin tests_failed++; $display("FAIL lu_clear got %0b want 0", load_use_hazard_o); end
    @(negedge clk_i);
    tests_run += 2;
    if (ex_valid_o !== 1'b1) begin tests_failed++; $display("FAIL lu_resume_valid got %0b want 1", ex_valid_o); end
    if (ex_rd_o !== 5'd9) begin tests_failed++; $display("FAIL lu_resume_rd got %0d want 9", ex_rd_o); end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    drive_id(2'b10, 4'b0000, 5'd1, 5'd2, 5'd4, 64'd100, 64'd200, 64'd0, 1'b0, 5'b10000);
    @(negedge clk_i);
    stall_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive_id(2'b10, 4'b1000, 5'd11, 5'd12, 5'd9, 64'd5 + 64'(c), 64'd6, 64'd7, 1'b1, 5'b01100);
      @(negedge clk_i);
      tests_run++;
      if (alu_src1_o !== 64'd100 || alu_src2_o !== 64'd200 || alu_ctrl_o !== 4'b0010 ||
          ex_rd_o !== 5'd4 || ex_valid_o !== 1'b1 || ex_ctl_o !== 5'b10000 || ex_store_data_o !== 64'd200) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d] got src1=%0d src2=%0d ctrl=%b rd=%0d v=%0b ctl=%b want 100 200 0010 4 1 10000",
                 c, alu_src1_o, alu_src2_o, alu_ctrl_o, ex_rd_o, ex_valid_o, ex_ctl_o);
      end
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    tests_run += 3;
    if (ex_valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_valid got %0b want 0", ex_valid_o); end
    if (ex_ctl_o !== 5'b00000) begin tests_failed++; $display("FAIL flush_ctl got %b want 00000", ex_ctl_o); end
    if (alu_src1_o !== 64'd0) begin tests_failed++; $display("FAIL flush_src1 got %0d want 0", alu_src1_o); end
    flush_i = 1'b0; stall_i = 1'b0;
  endtask

  task automatic test_itype();
    clear_inputs();
    drive_id(2'b11, 4'b1010, 5'd10, 5'd0, 5'd12, 64'h50, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 5'b10000);
    @(negedge clk_i);
    tests_run += 3;
    if (alu_ctrl_o !== 4'b0111) begin tests_failed++; $display("FAIL itype_ctrl got %b want 0111", alu_ctrl_o); end
    if (alu_src2_o !== 64'hFFFF_FFFF_FFFF_FFFD) begin tests_failed++; $display("FAIL itype_src2 got %h want fffffffffffffffd", alu_src2_o); end
    if (alu_src1_o !== 64'h50) begin tests_failed++; $display("FAIL itype_src1 got %h want 50", alu_src1_o); end
  endtask

  task automatic test_reset_in_stall();
    clear_inputs();
    drive_id(2'b10, 4'b0110, 5'd1, 5'd2, 5'd7, 64'd21, 64'd22, 64'd23, 1'b1, 5'b11010);
    @(negedge clk_i);
    tests_run++;
    if (ex_valid_o !== 1'b1) begin tests_failed++; $display("FAIL rs_pre_valid got %0b want 1", ex_valid_o); end
    stall_i = 1'b1;
    drive_id(2'b10, 4'b0000, 5'd7, 5'd3, 5'd8, 64'd1, 64'd2, 64'd0, 1'b0, 5'b10000);
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (load_use_hazard_o !== 1'b0) begin tests_failed++; $display("FAIL rs_hazard_in_reset got %0b want 0", load_use_hazard_o); end
    @(negedge clk_i);
    tests_run++;
    if (ex_valid_o !== 1'b0 || ex_ctl_o !== 5'b00000 || ex_rd_o !== 5'd0 || alu_src1_o !== 64'd0 ||
        alu_src2_o !== 64'd0 || ex_store_data_o !== 64'd0 || alu_ctrl_o !== 4'b0010 || load_use_hazard_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rs_outputs got v=%0b ctl=%b rd=%0d s1=%h s2=%h st=%h ctrl=%b hz=%0b want reset values",
               ex_valid_o, ex_ctl_o, ex_rd_o, alu_src1_o, alu_src2_o, ex_store_data_o, alu_ctrl_o, load_use_hazard_o);
    end
    rst_i = 1'b0; stall_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    test_reset();
    test_decode();
    test_forwarding();
    test_load_use();
    test_stall_flush();
    test_itype();
    test_reset_in_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
